// File: rtl/spi_controller_if.sv
// Request/status and SPI pin bundle for spi_controller.
// The master modport belongs to the requester; the slave modport belongs to the controller.
interface spi_controller_if;
    logic       req_valid;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       nCS_out;
    logic       SCLK_out;
    logic       COPI_out;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, busy, done, err, nCS_out, SCLK_out, COPI_out
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, busy, done, err, nCS_out, SCLK_out, COPI_out
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 register-write controller: 16-bit frame {1'b1, addr[6:0], data[7:0]}, MSB first.
// Define SPI_CTRL_ADDR_CHECK_EN to reject requests whose address exceeds MAX_ADDR.
//
// state  | meaning
// IDLE   | ready for a request, SPI pins idle
// SHIFT  | nCS low, 16 bits clocked out (low phase then high phase per bit)
// HOLD   | SCLK low for CLK_DIV cycles before nCS rises
// GAP    | nCS high for CS_GAP cycles before the next request
// REJECT | one-cycle err pulse for an out-of-range address
module spi_controller #(
    parameter int         CLK_DIV  = 4,
    parameter int         CS_GAP   = 4,
    parameter logic [6:0] MAX_ADDR = 7'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus
);

`ifdef SPI_CTRL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_REJECT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        bits_left, bits_left_nxt;
    logic [15:0]       shreg, shreg_nxt;
    logic              ncs_q, ncs_nxt;
    logic              sclk_q, sclk_nxt;
    logic              copi_q, copi_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              ready;
    logic              accept;
    logic              addr_bad;

    assign ready    = (state == ST_IDLE) && rst_n;
    assign accept   = bus.req_valid && ready;
    assign addr_bad = ADDR_CHECK && (bus.req_addr > MAX_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bits_left <= '0;
            shreg     <= '0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bits_left <= bits_left_nxt;
            shreg     <= shreg_nxt;
            ncs_q     <= ncs_nxt;
            sclk_q    <= sclk_nxt;
            copi_q    <= copi_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bits_left_nxt = bits_left;
        shreg_nxt     = shreg;
        ncs_nxt       = ncs_q;
        sclk_nxt      = sclk_q;
        copi_nxt      = copi_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        state_nxt = ST_REJECT;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = ST_SHIFT;
                        shreg_nxt     = {1'b1, bus.req_addr, bus.req_data};
                        ncs_nxt       = 1'b0;
                        sclk_nxt      = 1'b0;
                        copi_nxt      = 1'b1;
                        cnt_nxt       = DIV_LOAD;
                        bits_left_nxt = 4'd15;
                    end
                end
            end

            ST_SHIFT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    cnt_nxt = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        // End of a high phase: either the last bit is done or the next bit starts.
                        sclk_nxt = 1'b0;
                        if (bits_left == 4'd0) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            bits_left_nxt = bits_left - 1'b1;
                            shreg_nxt     = {shreg[14:0], 1'b0};
                            copi_nxt      = shreg[14];
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = ST_GAP;
                    ncs_nxt   = 1'b1;
                    copi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = GAP_LOAD;
                end
            end

            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_REJECT: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.busy      = (state == ST_SHIFT) || (state == ST_HOLD) || (state == ST_GAP);
    assign bus.done      = done_q;
    assign bus.err       = ADDR_CHECK ? err_q : 1'b0;
    assign bus.nCS_out   = ncs_q;
    assign bus.SCLK_out  = sclk_q;
    assign bus.COPI_out  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default instance (CLK_DIV=4, CS_GAP=4) and a CLK_DIV=2 instance.
// Negedge monitors capture COPI on SCLK rises, nCS timing and pulse counts.
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_controller_if bus_a ();
    spi_controller_if bus_b ();

    spi_controller #(.CLK_DIV(4), .CS_GAP(4), .MAX_ADDR(7'd4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    spi_controller #(.CLK_DIV(2), .CS_GAP(4), .MAX_ADDR(7'd4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int          checks = 0;
    int          errors = 0;

    int          cyc = 0;
    logic        a_prev_sclk = 1'b0;
    logic        a_prev_ncs  = 1'b1;
    logic [15:0] a_cap       = 16'h0;
    int          a_low = 0, a_done = 0, a_err = 0;
    int          a_fall = 0, a_rise = 0, a_done_cyc = 0;

    logic        b_prev_sclk = 1'b0;
    logic [15:0] b_cap       = 16'h0;
    int          b_low = 0, b_done = 0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        a_prev_sclk <= bus_a.SCLK_out;
        a_prev_ncs  <= bus_a.nCS_out;
        if (bus_a.SCLK_out && !a_prev_sclk) a_cap <= {a_cap[14:0], bus_a.COPI_out};
        if (!bus_a.nCS_out) a_low <= a_low + 1;
        if (bus_a.done) begin
            a_done     <= a_done + 1;
            a_done_cyc <= cyc;
        end
        if (bus_a.err) a_err <= a_err + 1;
        if (a_prev_ncs && !bus_a.nCS_out) a_fall <= cyc;
        if (!a_prev_ncs && bus_a.nCS_out) a_rise <= cyc;
    end

    always @(negedge clk) begin
        b_prev_sclk <= bus_b.SCLK_out;
        if (bus_b.SCLK_out && !b_prev_sclk) b_cap <= {b_cap[14:0], bus_b.COPI_out};
        if (!bus_b.nCS_out) b_low <= b_low + 1;
        if (bus_b.done) b_done <= b_done + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int k;
    int lat;
    int low0, done0, err0, fall0;
    logic [4:0] b_seq;

    // Steps until dut_a is ready again; k counts negedges since the request was driven.
    task automatic wait_ready_a();
        while (!bus_a.req_ready && k < 400) begin
            step();
            k++;
        end
        lat = k - 1;
    endtask

    task automatic send_a(input logic [6:0] a, input logic [7:0] d);
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = a;
        bus_a.req_data  = d;
        step();
        bus_a.req_valid = 1'b0;
        k = 1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_a.req_valid = 1'b0;
        bus_a.req_addr  = 7'h0;
        bus_a.req_data  = 8'h0;
        bus_b.req_valid = 1'b0;
        bus_b.req_addr  = 7'h0;
        bus_b.req_data  = 8'h0;
        step();
        step();
        chk("rst_ready", bus_a.req_ready, 1'b0);
        chk("rst_ncs",   bus_a.nCS_out,   1'b1);
        chk("rst_sclk",  bus_a.SCLK_out,  1'b0);
        chk("rst_copi",  bus_a.COPI_out,  1'b0);
        chk("rst_busy",  bus_a.busy,      1'b0);
        chk("rst_done",  bus_a.done,      1'b0);
        chk("rst_err",   bus_a.err,       1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", bus_a.req_ready, 1'b1);

        // Single write addr 0x04 data 0x80
        low0 = a_low; done0 = a_done; err0 = a_err;
        send_a(7'h04, 8'h80);
        chk("s1_ncs_fall", bus_a.nCS_out,   1'b0);
        chk("s1_bit15",    bus_a.COPI_out,  1'b1);
        chk("s1_sclk_lo",  bus_a.SCLK_out,  1'b0);
        chk("s1_busy",     bus_a.busy,      1'b1);
        chk("s1_ready_lo", bus_a.req_ready, 1'b0);
        wait_ready_a();
        chk("s1_frame",    a_cap,           16'h8480);
        chk("s1_ncs_low",  a_low - low0,    132);
        chk("s1_done_cnt", a_done - done0,  1);
        chk("s1_done_at",  a_done_cyc,      a_rise);
        chk("s1_latency",  lat,             136);
        chk("s1_no_err",   a_err - err0,    0);
        chk("s1_idle_ncs", bus_a.nCS_out,   1'b1);
        chk("s1_idle_bsy", bus_a.busy,      1'b0);

        // Back-to-back with req_valid held high
        done0 = a_done;
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = 7'h02;
        bus_a.req_data  = 8'h3C;
        step();
        bus_a.req_addr  = 7'h03;
        bus_a.req_data  = 8'hA5;
        k = 1;
        while (bus_a.nCS_out == 1'b0 && k < 400) begin step(); k++; end
        chk("b2b_first_frame", a_cap, 16'h823C);
        fall0 = a_fall;
        k = 0;
        while (bus_a.nCS_out == 1'b1 && k < 40) begin step(); k++; end
        bus_a.req_valid = 1'b0;
        chk("b2b_gap", a_fall - a_rise, 5);
        chk("b2b_new_fall", (a_fall != fall0), 1'b1);
        k = 1;
        wait_ready_a();
        chk("b2b_second_frame", a_cap, 16'h83A5);
        chk("b2b_done_cnt", a_done - done0, 2);

        // Request inputs changed during SHIFT
        send_a(7'h01, 8'h5A);
        repeat (20) begin step(); k++; end
        bus_a.req_addr = 7'h7F;
        bus_a.req_data = 8'hFF;
        wait_ready_a();
        chk("latch_frame", a_cap, 16'h815A);
        chk("latch_latency", lat, 136);

        // Reset at cycle 50 of a frame
        done0 = a_done;
        send_a(7'h02, 8'h11);
        while (k < 50) begin step(); k++; end
        rst_n = 1'b0;
        step();
        chk("abort_ncs",   bus_a.nCS_out,   1'b1);
        chk("abort_sclk",  bus_a.SCLK_out,  1'b0);
        chk("abort_busy",  bus_a.busy,      1'b0);
        chk("abort_ready", bus_a.req_ready, 1'b0);
        rst_n = 1'b1;
        low0 = a_low;
        repeat (150) step();
        chk("abort_no_done",   a_done - done0, 0);
        chk("abort_no_resume", a_low - low0,   0);
        chk("abort_ready_back", bus_a.req_ready, 1'b1);
        send_a(7'h03, 8'h99);
        wait_ready_a();
        chk("post_abort_frame", a_cap, 16'h8399);
        chk("post_abort_done",  a_done - done0, 1);

        // CLK_DIV=2 instance
        low0 = b_low; done0 = b_done;
        b_seq = 5'b00110;
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 7'h7F;
        bus_b.req_data  = 8'h0F;
        step();
        bus_b.req_valid = 1'b0;
        k = 1;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("div2_sclk_%0d", i), bus_b.SCLK_out, b_seq[5-i]);
            if (i < 5) begin step(); k++; end
        end
        while (!bus_b.req_ready && k < 200) begin step(); k++; end
        chk("div2_frame",   b_cap,          16'hFF0F);
        chk("div2_ncs_low", b_low - low0,   66);
        chk("div2_latency", k - 1,          70);
        chk("div2_done",    b_done - done0, 1);

        // Address above MAX_ADDR
        low0 = a_low; done0 = a_done; err0 = a_err;
        send_a(7'h05, 8'h42);
`ifdef SPI_CTRL_ADDR_CHECK_EN
        chk("rej_err_pulse", bus_a.err,     1'b1);
        chk("rej_ncs",       bus_a.nCS_out, 1'b1);
        wait_ready_a();
        chk("rej_latency",   lat,           1);
        repeat (10) step();
        chk("rej_err_cnt",   a_err - err0,  1);
        chk("rej_no_frame",  a_low - low0,  0);
        chk("rej_no_done",   a_done - done0, 0);
`else
        chk("addr5_ncs",     bus_a.nCS_out, 1'b0);
        wait_ready_a();
        chk("addr5_frame",   a_cap,          16'h8542);
        chk("addr5_latency", lat,            136);
        chk("addr5_no_err",  a_err - err0,   0);
        chk("addr5_done",    a_done - done0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
